// File: rtl/level_controller_if.sv
// Bundles the control-loop handshake between the sample source, the PI stage and
// the DAC driver.
//   enable        : loop enable (low clears integrator, forces level to 0)
//   setpoint      : target temperature code, unsigned
//   measure       : measured temperature code, unsigned
//   measure_valid : single-cycle strobe qualifying measure
//   level         : registered drive level for the DAC driver
//   level_valid   : one-cycle pulse after level updates
//   busy          : calculation in progress
interface level_controller_if;
  logic       enable;
  logic [7:0] setpoint;
  logic [7:0] measure;
  logic       measure_valid;
  logic [7:0] level;
  logic       level_valid;
  logic       busy;

  modport master (
    output enable, setpoint, measure, measure_valid,
    input  level, level_valid, busy
  );

  modport slave (
    input  enable, setpoint, measure, measure_valid,
    output level, level_valid, busy
  );
endinterface

// File: rtl/level_controller.sv
// Discrete PI control-law stage for the temperature loop. A five-state multicycle
// datapath computes an 8-bit drive level from setpoint and a strobed measurement,
// with a clamped integrator and saturated output.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : level_controller_if slave (enable, setpoint, measure, measure_valid in;
//           level, level_valid, busy out)
module level_controller #(
  parameter int unsigned KP      = 4,
  parameter int unsigned KI      = 1,
  parameter int unsigned FRAC    = 2,
  parameter int unsigned INT_LIM = 4095
) (
  input logic               clock,
  input logic               reset,
  level_controller_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StErr, StInteg, StSum, StSat} state_e;

  localparam logic signed [16:0] KpS       = 17'(KP);
  localparam logic signed [16:0] KiS       = 17'(KI);
  localparam logic signed [16:0] IntLim    = 17'(INT_LIM);
  localparam logic signed [16:0] IntLimNeg = -IntLim;

  state_e             state_q, state_d;
  logic [7:0]         meas_q, meas_d;
  logic [7:0]         sp_q, sp_d;
  logic [7:0]         level_q, level_d;
  logic               level_valid_q, level_valid_d;
  logic signed [8:0]  err_q, err_d;
  logic signed [15:0] integ_q, integ_d;
  logic signed [16:0] u_q, u_d;

  // 17-bit working values: wide enough that neither sum can wrap.
  logic signed [16:0] err_ext, integ_ext, integ_sum, pi_sum;

  assign err_ext   = {{8{err_q[8]}}, err_q};
  assign integ_ext = {integ_q[15], integ_q};
  assign integ_sum = integ_ext + KiS * err_ext;
  assign pi_sum    = KpS * err_ext + integ_ext;

  assign bus.level       = level_q;
  assign bus.level_valid = level_valid_q;
  assign bus.busy        = (state_q != StIdle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    meas_d        = meas_q;
    sp_d          = sp_q;
    err_d         = err_q;
    integ_d       = integ_q;
    u_d           = u_q;
    level_d       = level_q;
    level_valid_d = 1'b0;

    if (!bus.enable) begin
      // Abort anything in flight and park the loop at zero drive.
      state_d = StIdle;
      integ_d = '0;
      level_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.measure_valid) begin
            meas_d  = bus.measure;
            sp_d    = bus.setpoint;
            state_d = StErr;
          end
        end
        StErr: begin
          err_d   = $signed({1'b0, sp_q}) - $signed({1'b0, meas_q});
          state_d = StInteg;
        end
        StInteg: begin
          if (integ_sum > IntLim) begin
            integ_d = IntLim[15:0];
          end else if (integ_sum < IntLimNeg) begin
            integ_d = IntLimNeg[15:0];
          end else begin
            integ_d = integ_sum[15:0];
          end
          state_d = StSum;
        end
        StSum: begin
          u_d     = pi_sum >>> FRAC;
          state_d = StSat;
        end
        StSat: begin
          if (u_q[16]) begin
            level_d = 8'd0;
          end else if (u_q > 17'sd255) begin
            level_d = 8'd255;
          end else begin
            level_d = u_q[7:0];
          end
          level_valid_d = 1'b1;
          state_d       = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meas_q        <= '0;
      sp_q          <= '0;
      err_q         <= '0;
      integ_q       <= '0;
      u_q           <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
    end else begin
      meas_q        <= meas_d;
      sp_q          <= sp_d;
      err_q         <= err_d;
      integ_q       <= integ_d;
      u_q           <= u_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
    end
  end

endmodule

// File: tb/tb_level_controller.sv
// Directed bench for level_controller with default parameters.
module tb_level_controller;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  int   last_level;
  int   pulses;

  level_controller_if bus_if ();

  level_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus_if.measure_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    last_level = 0;
  endtask

  // Strobe one sample and follow it through the fixed 5-cycle schedule.
  task automatic run_sample(input int sp, input int ms, input int exp_level);
    bus_if.setpoint      = 8'(sp);
    bus_if.measure       = 8'(ms);
    bus_if.measure_valid = 1'b1;
    tick();  // E0
    bus_if.measure_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("busy", int'(bus_if.busy), 1);
      check("lv_early", int'(bus_if.level_valid), 0);
      check("level_hold", int'(bus_if.level), last_level);
      tick();
    end
    // After E4
    check("busy_done", int'(bus_if.busy), 0);
    check("lv_pulse", int'(bus_if.level_valid), 1);
    check("level", int'(bus_if.level), exp_level);
    tick();
    check("lv_end", int'(bus_if.level_valid), 0);
    check("level_held", int'(bus_if.level), exp_level);
    last_level = exp_level;
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    last_level           = 0;
    clock                = 1'b0;
    reset                = 1'b1;
    bus_if.enable        = 1'b0;
    bus_if.setpoint      = 8'd0;
    bus_if.measure       = 8'd0;
    bus_if.measure_valid = 1'b0;

    tick();
    tick();
    check("rst_level", int'(bus_if.level), 0);
    check("rst_lv", int'(bus_if.level_valid), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_integ", int'(dut.integ_q), 0);
    reset         = 1'b0;
    bus_if.enable = 1'b1;
    tick();

    // 1: basic path and integrator accumulation
    run_sample(100, 80, 25);
    check("s1_integ", int'(dut.integ_q), 20);
    run_sample(100, 80, 30);
    check("s1_integ2", int'(dut.integ_q), 40);

    // 2: negative saturation
    do_reset();
    run_sample(100, 200, 0);
    check("s2_integ", int'(dut.integ_q), -100);
    check("s2_u", int'(dut.u_q), -125);

    // 3: windup clamp
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      run_sample(255, 0, 255);
      if (i == 16) check("s3_integ16", int'(dut.integ_q), 4080);
      if (i == 17) check("s3_integ17", int'(dut.integ_q), 4095);
    end
    run_sample(0, 255, 255);
    check("s3_unwind_integ", int'(dut.integ_q), 3840);
    check("s3_unwind_u", int'(dut.u_q), 705);

    // 4: strobe during a calculation is dropped
    do_reset();
    bus_if.setpoint      = 8'd100;
    bus_if.measure       = 8'd80;
    bus_if.measure_valid = 1'b1;
    tick();  // E0
    bus_if.measure_valid = 1'b0;
    tick();  // E1
    bus_if.measure_valid = 1'b1;
    tick();  // E2
    bus_if.measure_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      pulses += int'(bus_if.level_valid);
      tick();
    end
    check("s4_pulses", pulses, 1);
    check("s4_level", int'(bus_if.level), 25);
    check("s4_integ", int'(dut.integ_q), 20);
    check("s4_busy", int'(bus_if.busy), 0);
    last_level = 25;

    // 5: enable dropped mid-calculation
    bus_if.measure_valid = 1'b1;
    tick();  // E0
    bus_if.measure_valid = 1'b0;
    tick();  // E1
    bus_if.enable = 1'b0;
    tick();  // E2
    check("s5_level", int'(bus_if.level), 0);
    check("s5_integ", int'(dut.integ_q), 0);
    check("s5_busy", int'(bus_if.busy), 0);
    check("s5_lv", int'(bus_if.level_valid), 0);
    tick();
    check("s5_lv2", int'(bus_if.level_valid), 0);
    bus_if.enable = 1'b1;
    last_level = 0;
    tick();
    run_sample(100, 80, 25);

    // 6: asynchronous reset during SUM
    bus_if.measure_valid = 1'b1;
    tick();  // E0
    bus_if.measure_valid = 1'b0;
    tick();  // E1
    tick();  // E2: now in SUM
    #2;
    reset = 1'b1;
    #1;
    check("s6_level", int'(bus_if.level), 0);
    check("s6_busy", int'(bus_if.busy), 0);
    tick();
    check("s6_lv", int'(bus_if.level_valid), 0);
    reset = 1'b0;
    tick();
    check("s6_lv2", int'(bus_if.level_valid), 0);
    check("s6_level2", int'(bus_if.level), 0);
    check("s6_integ", int'(dut.integ_q), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/level_controller.md
# level_controller

Discrete PI control-law stage for the temperature loop. Accepts a setpoint and a strobed temperature measurement and computes an 8-bit drive level through a five-state multicycle datapath. The result is held stable on `level`, which feeds the `level` input of the serial DAC driver directly downstream. It includes anti-windup clamping and output saturation.

## Interface

**Parameters**
- `KP`, default 4: proportional gain, unsigned, range 0..15.
- `KI`, default 1: integral gain, unsigned, range 0..15.
- `FRAC`, default 2: arithmetic right shift applied to the PI sum, range 0..7.
- `INT_LIM`, default 4095: symmetric integrator clamp magnitude, range 1..32767.

**Ports**
- `clock` in 1: sole clock; everything is updated on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: loop enable. When low, the integrator is cleared and the output is forced to 0.
- `setpoint` in 8: target temperature code, unsigned.
- `measure` in 8: measured temperature code, unsigned.
- `measure_valid` in 1: single-cycle strobe qualifying `measure`.
- `level` out 8: registered drive level, unsigned, for the DAC driver.
- `level_valid` out 1: one-cycle pulse, high in the cycle after `level` updates.
- `busy` out 1: high while a calculation is in progress.

## Operation

- **Internal registers**
  - `meas_r` and `sp_r`: 8 bits each.
  - `err`: signed, 9 bits.
  - `integ`: signed, 16 bits.
  - `u`: signed, 17 bits.
- **FSM states:** IDLE, ERR, INTEG, SUM, SAT.
- **IDLE**
  - If `enable` and `measure_valid` are both high: capture `measure` into `meas_r` and `setpoint` into `sp_r`, then go to ERR.
  - Otherwise stay in IDLE.
- **ERR:** `err = sp_r - meas_r`, evaluated with 9-bit sign extension. Range is -255..+255. Go to INTEG.
- **INTEG**
  - `integ = clamp(integ + KI*err, -INT_LIM, +INT_LIM)`.
  - The sum is evaluated at 17 bits before clamping, so it never wraps.
  - Go to SUM.
- **SUM**
  - `u = (KP*err + integ) >>> FRAC`.
  - The shift is arithmetic, i.e. floor toward negative infinity.
  - The intermediate is 17 bits signed; KP*err needs at most 13 bits.
  - Go to SAT.
- **SAT**
  - `level` is set to 0 if `u` < 0, to 255 if `u` > 255, and to `u[7:0]` otherwise.
  - Assert `level_valid` for the next cycle, then go to IDLE.
- **`busy`:** equals 1 in ERR, INTEG, SUM and SAT, and 0 in IDLE.
- **Dropped strobes:** `measure_valid` arriving while `busy` is high is ignored. There is no queueing.
- **`setpoint` timing:** `setpoint` is sampled only at acceptance. Changes mid-calculation apply to the next sample.
- **`enable` low, any state**
  - On the next edge: state goes to IDLE, `integ` to 0, `level` to 0, `level_valid` to 0.
  - An in-flight calculation is discarded.
- **`enable` low with `measure_valid` high in the same cycle:** the sample is not accepted.

## Timing

- **Reset values (asynchronous):** state=IDLE, `level`=0, `level_valid`=0, `busy`=0, `integ`=0, `err`=0, `u`=0.
- **Latency:** take the acceptance edge as E0, with `measure_valid` sampled high in IDLE.
  - ERR at E1, INTEG at E2, SUM at E3.
  - `level` is written at E4 and is visible after E4.
  - `level_valid` is high for exactly the cycle between E4 and E5.
- **`busy` and throughput**
  - `busy` is high from after E0 through E4, and low after E4.
  - The earliest next acceptance is E5, so maximum throughput is one sample per 5 clocks.
- **`level` stability:** `level` changes only at a SAT edge, or at the edge following `enable` low or `reset`. It is otherwise held indefinitely, which the DAC driver relies on to capture `level` in any cycle.
- **Reset mid-operation:** all registers return to reset values immediately. No `level_valid` pulse is generated.

## Test plan

Defaults apply throughout (KP=4, KI=1, FRAC=2, INT_LIM=4095).

1. **Basic path and latency.** Reset, `enable`=1, `setpoint`=100, `measure`=80, strobe. Required:
   - `busy` high for 4 cycles.
   - After E4, `level`=25 (err=20, integ=20, (80+20)>>>2).
   - `level_valid` is a single-cycle pulse.
   - A second identical strobe gives integ=40 and `level`=30.
2. **Negative saturation.** From reset, `setpoint`=100, `measure`=200. Required: err=-100, integ=-100, u=-125, so `level`=0.
3. **Windup clamp.** `setpoint`=255, `measure`=0, strobed 17 times. Required:
   - integ reads 4080 after the 16th sample and clamps to 4095 on the 17th.
   - `level`=255 every time.
   - Then `measure`=255, `setpoint`=0, one strobe: integ=3840, u=705, so `level`=255.
4. **Dropped strobe.** Pulse `measure_valid` at E2 of an active calculation. Required:
   - No effect: exactly one `level_valid` pulse results.
   - integ has been updated once only.
5. **Enable abort.** Drop `enable` at E2 of a calculation. Required:
   - Next edge: `level`=0, integ=0, `busy`=0, and no `level_valid` pulse.
   - Re-enable, then scenario 1's stimulus again gives `level`=25.
6. **Async reset.** Assert `reset` mid-SUM, between edges. Required: `level`=0 and `busy`=0 immediately, before the next clock edge.
